// File: rtl/satu_rr_scheduler.sv
// Round-robin, burst-locking scheduler that shares one registered INT18->INT16 saturator among NUM_REQ lanes.
// Optional saturation statistics (sat_count, stats_clr) are built only when SATU_STATS_EN is defined.
module satu_rr_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int IN_W      = 18,
   parameter int OUT_W     = 16,
   parameter int ID_W      = 2,
   parameter int BURST_LEN = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*IN_W-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    out_valid,
   output logic [OUT_W-1:0]        out_data,
   output logic [ID_W-1:0]         out_id,
   output logic                    out_sat,
   input  logic                    out_ready,
   output logic                    busy
`ifdef SATU_STATS_EN
   ,
   output logic [31:0]             sat_count,
   input  logic                    stats_clr
`endif
);

   localparam int K     = IN_W - OUT_W + 1;
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   // Handshake: a beat moves on a lane in a cycle where req_valid[i] & req_ready[i]
   // at the rising edge; the result leaves when out_valid & out_ready at the edge.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic [ID_W-1:0]   out_id_q, out_id_d;
   logic              out_sat_q, out_sat_d;

   logic [ID_W-1:0]   idle_owner;
   logic [ID_W-1:0]   owner;
   logic              found;
   logic              have_owner;
   logic              can_load;
   logic              owner_valid;
   logic              accept;
   logic              release_own;
   logic [CNT_W-1:0]  cnt_inc;
   logic [IN_W-1:0]   sel_data;
   logic [K-1:0]      top_bits;
   logic [OUT_W-1:0]  sat_data;
   logic              sat_clip;

   // First valid lane at or after ptr, wrapping around.
   always_comb begin : arbiter
      int              lane;
      logic [ID_W-1:0] lane_idx;
      found      = 1'b0;
      idle_owner = ptr_q;
      lane       = 0;
      lane_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         lane = int'(ptr_q) + k;
         if (lane >= NUM_REQ) lane = lane - NUM_REQ;
         lane_idx = ID_W'(lane);
         if (!found && req_valid[lane_idx]) begin
            found      = 1'b1;
            idle_owner = lane_idx;
         end
      end
   end

   always_comb begin : grant
      owner       = (state_q == ST_LOCK) ? owner_q : idle_owner;
      have_owner  = (state_q == ST_LOCK) | found;
      can_load    = !out_valid_q | out_ready;
      owner_valid = req_valid[owner];
      accept      = have_owner & can_load & owner_valid;
      req_ready   = '0;
      if (have_owner && can_load) req_ready[owner] = 1'b1;
   end

   always_comb begin : saturate
      sel_data = req_data[owner*IN_W +: IN_W];
      top_bits = sel_data[IN_W-1 -: K];
      sat_clip = 1'b0;
      sat_data = sel_data[OUT_W-1:0];
      if (!sel_data[IN_W-1] && (|top_bits)) begin
         sat_clip = 1'b1;
         sat_data = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (sel_data[IN_W-1] && !(&top_bits)) begin
         sat_clip = 1'b1;
         sat_data = {1'b1, {(OUT_W-1){1'b0}}};
      end
   end

   always_comb begin : fsm_next
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      release_own = 1'b0;
      cnt_inc     = cnt_q + CNT_W'(1);
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (BURST_LEN == 1) begin
                  release_own = 1'b1;
               end else begin
                  state_d = ST_LOCK;
                  owner_d = owner;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_LOCK: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(BURST_LEN)) release_own = 1'b1;
            end else if (!owner_valid) begin
               release_own = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (release_own) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ptr_d   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
      end
   end

   // A new load replaces the held result in the same edge, so no bubble under out_ready.
   always_comb begin : out_next
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      out_sat_d   = out_sat_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sat_data;
         out_id_d    = owner;
         out_sat_d   = sat_clip;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign out_sat   = out_sat_q;
   assign busy      = (state_q == ST_LOCK) | out_valid_q;

`ifdef SATU_STATS_EN
   logic [31:0] sat_count_q, sat_count_d;

   // Clear wins over a coinciding clipped load; the count sticks at all-ones.
   always_comb begin
      sat_count_d = sat_count_q;
      if (stats_clr) begin
         sat_count_d = '0;
      end else if (accept && sat_clip && (sat_count_q != 32'hFFFF_FFFF)) begin
         sat_count_d = sat_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_count_q <= '0;
      else        sat_count_q <= sat_count_d;
   end

   assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_satu_rr_scheduler.sv
// Randomized scoreboard bench for satu_rr_scheduler; covers SATU_STATS_EN when that macro is defined.
module tb_satu_rr_scheduler;

   localparam int NUM_REQ   = 4;
   localparam int IN_W      = 18;
   localparam int OUT_W     = 16;
   localparam int ID_W      = 2;
   localparam int BURST_LEN = 3;
   localparam int EW        = ID_W + 1 + OUT_W;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*IN_W-1:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    out_valid;
   logic [OUT_W-1:0]        out_data;
   logic [ID_W-1:0]         out_id;
   logic                    out_sat;
   logic                    out_ready;
   logic                    busy;
`ifdef SATU_STATS_EN
   logic [31:0]             sat_count;
   logic                    stats_clr;
`endif

   satu_rr_scheduler #(
      .NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W), .BURST_LEN(BURST_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_sat(out_sat), .out_ready(out_ready), .busy(busy)
`ifdef SATU_STATS_EN
      , .sat_count(sat_count), .stats_clr(stats_clr)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];

   // Reference model state (arbitration described as lane numbers and counters)
   int      m_ptr = 0, m_owner = 0, m_cnt = 0;
   bit      m_locked = 0, m_out_valid = 0;
   longint  m_sat = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Saturation in plain signed arithmetic: returns {clipped, value}.
   function automatic logic [OUT_W:0] sat_ref(input logic [IN_W-1:0] d);
      int v;
      int vmax, vmin;
      logic [OUT_W-1:0] r;
      v = int'(d);
      if (d[IN_W-1]) v = v - (1 << IN_W);
      vmax = (1 << (OUT_W - 1)) - 1;
      vmin = -(1 << (OUT_W - 1));
      if (v > vmax) v = vmax;
      else if (v < vmin) v = vmin;
      else begin
         r = v[OUT_W-1:0];
         return {1'b0, r};
      end
      r = v[OUT_W-1:0];
      return {1'b1, r};
   endfunction

   // ---------------- reference model ----------------
   always @(negedge clk) begin : model_b
      int owner;
      bit have, can_load, acc;
      logic [NUM_REQ-1:0] exp_ready;
      logic [OUT_W:0] r;
      if (!rst_n) begin
         m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_out_valid = 0; m_sat = 0;
         exp_q.delete();
      end else begin
         check("out_valid", out_valid, m_out_valid);
         check("busy", busy, m_locked || m_out_valid);
`ifdef SATU_STATS_EN
         check("sat_count", sat_count, m_sat);
`endif
         can_load = !m_out_valid || out_ready;
         have  = m_locked;
         owner = m_owner;
         if (!m_locked) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (!have && req_valid[(m_ptr + k) % NUM_REQ]) begin
                  have  = 1;
                  owner = (m_ptr + k) % NUM_REQ;
               end
            end
         end
         exp_ready = '0;
         if (have && can_load) exp_ready[owner] = 1'b1;
         check("req_ready", req_ready, exp_ready);
         acc = have && can_load && req_valid[owner];
         r = '0;
         if (acc) begin
            r = sat_ref(req_data[owner*IN_W +: IN_W]);
            exp_q.push_back({ID_W'(owner), r});
         end
`ifdef SATU_STATS_EN
         if (stats_clr) m_sat = 0;
         else if (acc && r[OUT_W] && m_sat != 64'hFFFF_FFFF) m_sat++;
`endif
         if (acc) begin
            if (!m_locked) begin
               m_locked = 1; m_owner = owner; m_cnt = 0;
            end
            m_cnt++;
            if (m_cnt == BURST_LEN) begin
               m_locked = 0; m_cnt = 0; m_ptr = (owner + 1) % NUM_REQ;
            end
         end else if (m_locked && !req_valid[owner]) begin
            m_locked = 0; m_cnt = 0; m_ptr = (owner + 1) % NUM_REQ;
         end
         m_out_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_out_valid);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor_b
      logic [EW-1:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("out_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_id", out_id, e[EW-1 -: ID_W]);
            check("out_sat", out_sat, e[OUT_W]);
            check("out_data", out_data, e[OUT_W-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int lane, input logic [IN_W-1:0] d);
      bit done;
      done = 0;
      req_valid = '0;
      req_valid[lane] = 1'b1;
      req_data[lane*IN_W +: IN_W] = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = req_ready[lane];
         @(posedge clk); #2;
      end
      if (!done) check("send_timeout", 0, 1);
      req_valid = '0;
   endtask

   function automatic logic [IN_W-1:0] rand_word();
      logic [IN_W-1:0] w;
      case ($urandom_range(0, 3))
         0: w = IN_W'($urandom);
         1: w = IN_W'($urandom_range(0, 32767));
         2: begin
            case ($urandom_range(0, 3))
               0: w = 18'h07FFF;
               1: w = 18'h08000;
               2: w = 18'h38000;
               default: w = 18'h37FFF;
            endcase
         end
         default: w = IN_W'(-int'($urandom_range(0, 32768)));
      endcase
      return w;
   endfunction

   task automatic randomize_data();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*IN_W +: IN_W] = rand_word();
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
`ifdef SATU_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      #1; rst_n = 1'b1;
      out_ready = 1'b1;
      idle_cycles(1);

      // Single lane: pass/clip at both ends of the range
      send(0, 18'h07FFF);
      send(0, 18'h10000);
      send(0, 18'h38000);
      send(0, 18'h20000);
      idle_cycles(3);

      // Lane 0 locked while downstream stalls for 5 cycles
      randomize_data();
      req_valid = 4'b0001;
      idle_cycles(1);
      out_ready = 1'b0;
      idle_cycles(5);
      out_ready = 1'b1;
      idle_cycles(4);

      // All lanes streaming
      req_valid = '1;
      for (int c = 0; c < 24; c++) begin
         randomize_data();
         idle_cycles(1);
      end

      // Lane 1 drops mid-burst while lanes 0 and 2 keep requesting
      req_valid = '0;
      idle_cycles(3);
      req_valid = 4'b0010;
      idle_cycles(2);
      req_valid = 4'b0101;
      idle_cycles(6);

      // Random traffic with random backpressure
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_REQ; i++)
            if ($urandom_range(0, 9) < 3) req_valid[i] = ~req_valid[i];
         randomize_data();
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef SATU_STATS_EN
         stats_clr = ($urandom_range(0, 49) == 0);
`endif
         idle_cycles(1);
      end
`ifdef SATU_STATS_EN
      stats_clr = 1'b0;
`endif

      // Reset in the middle of a burst with a result pending
      req_valid = '1; out_ready = 1'b1;
      randomize_data();
      idle_cycles(2);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_id", out_id, 0);
      check("arst_out_sat", out_sat, 0);
      check("arst_busy", busy, 0);
      check("arst_req_ready", req_ready, 0);
`ifdef SATU_STATS_EN
      check("arst_sat_count", sat_count, 0);
`endif
      idle_cycles(1);
      rst_n = 1'b1;
      req_valid = '1;
      @(negedge clk);
      check("restart_lane0", req_ready, 4'b0001);
      @(posedge clk); #2;
      for (int c = 0; c < 16; c++) begin
         randomize_data();
         idle_cycles(1);
      end
      req_valid = '0;
      idle_cycles(3);

`ifdef SATU_STATS_EN
      stats_clr = 1'b1;
      idle_cycles(1);
      stats_clr = 1'b0;
      send(2, 18'h10000);
      send(2, 18'h00123);
      send(2, 18'h20000);
      send(2, 18'h3F000);
      send(2, 18'h08000);
      idle_cycles(3);
      check("stats_three", sat_count, 3);
      stats_clr = 1'b1;
      @(posedge clk); #1;
      check("stats_cleared", sat_count, 0);
      #1; stats_clr = 1'b0;
      idle_cycles(1);
`endif

      // Drain: every accepted beat must have left the output register
      out_ready = 1'b1;
      req_valid = '0;
      idle_cycles(5);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
